// File: rtl/dma_responder_if.sv
// CPU, DMA-device and RAM signal bundle seen by dma_responder.
// The slave modport is the responder side; the master modport is the surrounding system.
interface dma_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              CPU_req;
  logic [ADDR_W-1:0] CPU_addr;
  logic [DATA_W-1:0] CPU_data;
  logic              CPU_wren;
  logic              CPU_stall;
  logic [DATA_W-1:0] CPU_q;
  logic              CPU_qvalid;

  logic              DMA_en;
  logic [ADDR_W-1:0] DMA_addr;
  logic [DATA_W-1:0] DMA_data;
  logic              DMA_wren;
  logic              DMA_CLOCK;
  logic [DATA_W-1:0] DMA_q;

  logic [ADDR_W-1:0] RAM_addr;
  logic [DATA_W-1:0] RAM_data;
  logic              RAM_wren;
  logic [DATA_W-1:0] RAM_q;

  modport slave (
    input  CPU_req, CPU_addr, CPU_data, CPU_wren,
    input  DMA_en, DMA_addr, DMA_data, DMA_wren,
    input  RAM_q,
    output CPU_stall, CPU_q, CPU_qvalid,
    output DMA_CLOCK, DMA_q,
    output RAM_addr, RAM_data, RAM_wren
  );

  modport master (
    output CPU_req, CPU_addr, CPU_data, CPU_wren,
    output DMA_en, DMA_addr, DMA_data, DMA_wren,
    output RAM_q,
    input  CPU_stall, CPU_q, CPU_qvalid,
    input  DMA_CLOCK, DMA_q,
    input  RAM_addr, RAM_data, RAM_wren
  );
endinterface

// File: rtl/dma_responder.sv
// Arbitrates single-port RAM between CPU and one DMA device: DMA word strobed 2 cycles after grant, CPU read data 1 cycle after grant.
// CPU stalls only in the cycle DMA takes the slot; DMA_WRITE_EN enables DMA writes (default build: DMA read-only).
module dma_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  dma_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    D_IDLE   = 2'd0,
    D_WAIT   = 2'd1,
    D_STROBE = 2'd2
  } dstate_e;

  dstate_e           state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              strobe_q, strobe_d;
  logic              cpu_qvalid_q, cpu_qvalid_d;
  logic              dma_wr_q, dma_wr_d;

  logic              dma_grant;
  logic              cpu_grant;
  logic              dma_wr_req;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;

`ifdef DMA_WRITE_EN
  assign dma_wr_req = bus.DMA_wren;
`else
  logic unused_dma_wren;
  assign dma_wr_req      = 1'b0;
  assign unused_dma_wren = bus.DMA_wren;
`endif

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    dma_rdata_d = dma_rdata_q;
    strobe_d    = 1'b0;
    dma_wr_d    = dma_wr_q;
    dma_grant   = 1'b0;

    case (state_q)
      D_IDLE: begin
        if (bus.DMA_en) begin
          if (!bus.CPU_req || (starve_q == CNT_W'(STARVE_MAX))) begin
            dma_grant = 1'b1;
            dma_wr_d  = dma_wr_req;
            state_d   = D_WAIT;
          end else if (starve_q != {CNT_W{1'b1}}) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      D_WAIT: begin
        // Writes echo the device's own data so it sees a uniform strobe.
        dma_rdata_d = dma_wr_q ? bus.DMA_data : bus.RAM_q;
        strobe_d    = 1'b1;
        state_d     = D_STROBE;
      end
      D_STROBE: begin
        state_d = D_IDLE;
      end
      default: begin
        state_d = D_IDLE;
      end
    endcase

    if (dma_grant || !bus.DMA_en) begin
      starve_d = '0;
    end

    cpu_grant    = bus.CPU_req & ~dma_grant;
    cpu_qvalid_d = cpu_grant & ~bus.CPU_wren;

    if (dma_grant) begin
      ram_addr = bus.DMA_addr;
      ram_data = bus.DMA_data;
      ram_wren = dma_wr_req;
    end else begin
      ram_addr = bus.CPU_addr;
      ram_data = bus.CPU_data;
      ram_wren = cpu_grant & bus.CPU_wren;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= D_IDLE;
      starve_q     <= '0;
      dma_rdata_q  <= '0;
      strobe_q     <= 1'b0;
      cpu_qvalid_q <= 1'b0;
      dma_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      dma_rdata_q  <= dma_rdata_d;
      strobe_q     <= strobe_d;
      cpu_qvalid_q <= cpu_qvalid_d;
      dma_wr_q     <= dma_wr_d;
    end
  end

  assign bus.RAM_addr   = ram_addr;
  assign bus.RAM_data   = ram_data;
  assign bus.RAM_wren   = ram_wren;
  assign bus.CPU_stall  = bus.CPU_req & ~cpu_grant;
  assign bus.CPU_q      = bus.RAM_q;
  assign bus.CPU_qvalid = cpu_qvalid_q;
  assign bus.DMA_CLOCK  = strobe_q;
  assign bus.DMA_q      = dma_rdata_q;

endmodule

// File: tb/tb_dma_responder.sv
// Directed bench for dma_responder: transaction-level model with a per-cycle compare, plus literal checks per scenario.
module tb_dma_responder;

  localparam int SMAX = 8;

  logic CLK;
  logic RST_N;

  dma_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dma_responder #(
    .ADDR_W(16), .DATA_W(16), .STARVE_MAX(SMAX), .CNT_W(8)
  ) u_dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bench-side synchronous RAM, driven only by the DUT's RAM port.
  logic [15:0] mem [0:65535];
  logic [15:0] ram_q;
  always @(posedge CLK) begin
    if (bus.RAM_wren) mem[bus.RAM_addr] <= bus.RAM_data;
    ram_q <= mem[bus.RAM_addr];
  end
  assign bus.RAM_q = ram_q;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: timestamps of outstanding events plus a shadow copy of RAM.
  logic [15:0] sh [0:65535];
  int          strobe_cyc = -1;
  int          idle_from  = 0;
  int          dq_upd_cyc = -1;
  logic [15:0] dq_upd_val = '0;
  logic [15:0] exp_dq     = '0;
  int          qv_cyc     = -1;
  logic [15:0] qv_val     = '0;
  int          m_starve   = 0;

  always @(negedge CLK) begin
    logic pend, win, cpu_go, wr, exp_wren;
    logic [15:0] exp_addr;
    if (!RST_N) begin
      chk("rst_dma_clock", bus.DMA_CLOCK, 0);
      chk("rst_dma_q", bus.DMA_q, 0);
      chk("rst_cpu_qvalid", bus.CPU_qvalid, 0);
      cyc = 0; strobe_cyc = -1; idle_from = 0; dq_upd_cyc = -1;
      exp_dq = '0; qv_cyc = -1; m_starve = 0;
    end else begin
      if (cyc == dq_upd_cyc) exp_dq = dq_upd_val;
      pend   = (cyc >= idle_from) && bus.DMA_en;
      win    = pend && (!bus.CPU_req || m_starve == SMAX);
      cpu_go = bus.CPU_req && !win;
`ifdef DMA_WRITE_EN
      wr = bus.DMA_wren;
`else
      wr = 1'b0;
`endif
      exp_addr = win ? bus.DMA_addr : bus.CPU_addr;
      exp_wren = win ? wr : (cpu_go && bus.CPU_wren);
      chk("m_ram_addr", bus.RAM_addr, exp_addr);
      chk("m_ram_wren", bus.RAM_wren, exp_wren);
      if (exp_wren) chk("m_ram_data", bus.RAM_data, win ? bus.DMA_data : bus.CPU_data);
      chk("m_cpu_stall", bus.CPU_stall, bus.CPU_req && !cpu_go);
      chk("m_cpu_qvalid", bus.CPU_qvalid, cyc == qv_cyc);
      if (cyc == qv_cyc) chk("m_cpu_q", bus.CPU_q, qv_val);
      chk("m_dma_clock", bus.DMA_CLOCK, cyc == strobe_cyc);
      chk("m_dma_q", bus.DMA_q, exp_dq);

      if (win) begin
        strobe_cyc = cyc + 2;
        idle_from  = cyc + 3;
        dq_upd_cyc = cyc + 2;
        dq_upd_val = wr ? bus.DMA_data : sh[bus.DMA_addr];
        if (wr) sh[bus.DMA_addr] = bus.DMA_data;
        m_starve = 0;
      end else if (!bus.DMA_en) begin
        m_starve = 0;
      end else if (pend && m_starve < 255) begin
        m_starve++;
      end
      if (cpu_go) begin
        if (bus.CPU_wren) sh[bus.CPU_addr] = bus.CPU_data;
        else begin
          qv_cyc = cyc + 1;
          qv_val = sh[bus.CPU_addr];
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [11:0] sv, qv, dc;
    logic [15:0] exp_w;
    int ns;
    RST_N = 1'b0;
    bus.CPU_req = 0; bus.CPU_addr = 0; bus.CPU_data = 0; bus.CPU_wren = 0;
    bus.DMA_en = 0; bus.DMA_addr = 0; bus.DMA_data = 0; bus.DMA_wren = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i) ^ 16'hA5A5;
      sh[i]  = 16'(i) ^ 16'hA5A5;
    end
    mem[16'hF000] = 16'h1234; sh[16'hF000] = 16'h1234;
    mem[16'h0010] = 16'hBEEF; sh[16'h0010] = 16'hBEEF;

    repeat (3) step();
    chk("reset_dma_clock", bus.DMA_CLOCK, 0);
    chk("reset_dma_q", bus.DMA_q, 0);
    chk("reset_qvalid", bus.CPU_qvalid, 0);

    // Basic DMA read, back-to-back grant, then DMA_en dropped in D_WAIT.
    RST_N = 1'b1;
    bus.DMA_en = 1; bus.DMA_addr = 16'hF000;
    @(negedge CLK); chk("t1_c0_ram_addr", bus.RAM_addr, 16'hF000);
    @(negedge CLK); chk("t1_c1_dma_clock", bus.DMA_CLOCK, 0);
    @(negedge CLK); chk("t1_c2_dma_clock", bus.DMA_CLOCK, 1);
                    chk("t1_c2_dma_q", bus.DMA_q, 16'h1234);
    step(); bus.DMA_addr = 16'hF001;
    @(negedge CLK); chk("t1_c3_dma_clock", bus.DMA_CLOCK, 0);
                    chk("t1_c3_regrant", bus.RAM_addr, 16'hF001);
    step(); bus.DMA_en = 0;
    @(negedge CLK);
    @(negedge CLK); chk("t6_strobe_after_drop", bus.DMA_CLOCK, 1);
                    chk("t6_dma_q", bus.DMA_q, 16'h55A4);
    ns = 0;
    repeat (6) begin @(negedge CLK); ns += int'(bus.DMA_CLOCK); end
    chk("t6_no_more_strobes", ns, 0);

    // CPU read serviced while DMA is in D_WAIT.
    step(); bus.DMA_en = 1; bus.DMA_addr = 16'hF000;
    step(); bus.CPU_req = 1; bus.CPU_addr = 16'h0010; bus.CPU_wren = 0;
    @(negedge CLK); chk("t3_no_stall", bus.CPU_stall, 0);
    step(); bus.CPU_req = 0;
    @(negedge CLK); chk("t3_qvalid", bus.CPU_qvalid, 1);
                    chk("t3_cpu_q", bus.CPU_q, 16'hBEEF);
                    chk("t3_dma_clock", bus.DMA_CLOCK, 1);
                    chk("t3_dma_q", bus.DMA_q, 16'h1234);
    step(); bus.DMA_en = 0;

    // Starvation: CPU reads every cycle, DMA wins on the ninth.
    step(); bus.CPU_req = 1; bus.CPU_wren = 0; bus.DMA_en = 1; bus.DMA_addr = 16'hF001;
    for (int i = 0; i < 12; i++) begin
      bus.CPU_addr = 16'h0020 + 16'(i);
      @(negedge CLK);
      sv[i] = bus.CPU_stall; qv[i] = bus.CPU_qvalid; dc[i] = bus.DMA_CLOCK;
      step();
    end
    chk("t2_stall_pattern", sv, 12'h100);
    chk("t2_qvalid_pattern", qv, 12'hDFE);
    chk("t2_strobe_pattern", dc, 12'h400);

    // Reset pulsed while DMA is in D_WAIT.
    bus.CPU_req = 0; bus.CPU_addr = 16'h0000; bus.DMA_en = 1; bus.DMA_addr = 16'hF000;
    @(negedge CLK); chk("t4_grant", bus.RAM_addr, 16'hF000);
    step(); RST_N = 1'b0;
    @(negedge CLK); chk("t4_rst_clock", bus.DMA_CLOCK, 0);
                    chk("t4_rst_q", bus.DMA_q, 0);
    step();
    @(negedge CLK); chk("t4_no_strobe", bus.DMA_CLOCK, 0);
    step(); RST_N = 1'b1;
    @(negedge CLK); chk("t4_first_cycle_grant", bus.RAM_addr, 16'hF000);
    @(negedge CLK);
    @(negedge CLK); chk("t4_strobe", bus.DMA_CLOCK, 1);
                    chk("t4_dma_q", bus.DMA_q, 16'h1234);
    step(); bus.DMA_en = 0;

    // DMA write attempt at 0x8000, then CPU reads it back.
`ifdef DMA_WRITE_EN
    exp_w = 16'h00AA;
`else
    exp_w = 16'h25A5;
`endif
    step(); bus.DMA_en = 1; bus.DMA_addr = 16'h8000; bus.DMA_data = 16'h00AA; bus.DMA_wren = 1;
    @(negedge CLK); chk("t5_ram_wren", bus.RAM_wren, (exp_w == 16'h00AA));
    step(); bus.DMA_en = 0;
    @(negedge CLK);
    @(negedge CLK); chk("t5_strobe", bus.DMA_CLOCK, 1);
                    chk("t5_dma_q", bus.DMA_q, exp_w);
    step(); bus.DMA_wren = 0; bus.CPU_req = 1; bus.CPU_addr = 16'h8000;
    step(); bus.CPU_req = 0;
    @(negedge CLK); chk("t5_readback", bus.CPU_q, exp_w);

    // CPU write then read back.
    step(); bus.CPU_req = 1; bus.CPU_wren = 1; bus.CPU_addr = 16'h0030; bus.CPU_data = 16'h1111;
    @(negedge CLK); chk("t7_cpu_wren", bus.RAM_wren, 1);
    step(); bus.CPU_wren = 0;
    @(negedge CLK); chk("t7_no_qvalid_on_write", bus.CPU_qvalid, 0);
    step(); bus.CPU_req = 0;
    @(negedge CLK); chk("t7_readback", bus.CPU_q, 16'h1111);

    // Mixed CPU/DMA traffic checked by the model alone.
    for (int i = 0; i < 24; i++) begin
      step();
      bus.CPU_req  = (i % 3) != 0;
      bus.CPU_wren = (i % 5) == 1;
      bus.CPU_addr = 16'h0040 + 16'(i % 4);
      bus.CPU_data = 16'h1000 + 16'(i);
      bus.DMA_en   = i < 18;
      bus.DMA_addr = 16'h0040 + 16'((i / 3) % 4);
    end
    step(); bus.CPU_req = 0; bus.DMA_en = 0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_responder.md
Name: dma_responder

Overview:
- Memory-side end of the device DMA interface: owns the single port of DCPU main RAM and arbitrates it between the CPU core and one DMA device (e.g. the monitor's VRAM fetcher).
- Serves each DMA word request and returns it on DMA_q, marked by a DMA_CLOCK strobe.
- The device samples DMA_q on the DMA_CLOCK rising edge and advances DMA_addr on the falling edge.
- Single clock domain; RAM is synchronous with 1-cycle read latency.

Parameters:
- ADDR_W, 16, RAM/DMA address width
- DATA_W, 16, word width
- STARVE_MAX, 8, number of consecutive cycles a pending DMA request may lose to the CPU before DMA is forced to win; 0 = DMA always has priority
- CNT_W, 8, starvation counter width (STARVE_MAX < 2^CNT_W)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset
- CPU_req  in  1  CPU access request, held until granted
- CPU_addr  in  ADDR_W  CPU address
- CPU_data  in  DATA_W  CPU write data
- CPU_wren  in  1  CPU write enable
- CPU_stall  out  1  request present but not granted this cycle
- CPU_q  out  DATA_W  CPU read data
- CPU_qvalid  out  1  CPU_q valid this cycle
- DMA_en  in  1  device requests continuous DMA
- DMA_addr  in  ADDR_W  DMA word address
- DMA_data  in  DATA_W  DMA write data
- DMA_wren  in  1  DMA write enable
- DMA_CLOCK  out  1  data strobe to device
- DMA_q  out  DATA_W  DMA read data, registered
- RAM_addr  out  ADDR_W  RAM address
- RAM_data  out  DATA_W  RAM write data
- RAM_wren  out  1  RAM write enable
- RAM_q  in  DATA_W  RAM read data, valid the cycle after address

Behaviour:
- Interface: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values: state D_IDLE, DMA_CLOCK=0, DMA_q=0, starve counter=0, CPU_qvalid=0.
- Reset asserted mid-operation aborts any in-flight access; no strobe and no qvalid are issued for it.
- One RAM slot per cycle.
- RAM_addr, RAM_data and RAM_wren are combinational from the granted requester.
- With no grant: RAM_wren=0 and RAM_addr=CPU_addr.
- DMA FSM states:
  - D_IDLE: DMA is pending iff DMA_en=1. When the DMA grant is won this cycle, the RAM is driven with DMA_addr/DMA_data/DMA_wren, and the FSM moves to D_WAIT.
  - D_WAIT: RAM_q is valid; DMA_q<=RAM_q for a read, DMA_q<=DMA_data for a write. Go to D_STROBE.
  - D_STROBE: DMA_CLOCK=1 for exactly this cycle. Go to D_IDLE.
  - DMA_CLOCK is low in every other state, so the device sees the falling edge entering D_IDLE. DMA_addr must be stable before the next grant.
  - Throughput is at most one DMA word per 3 cycles.
- Arbitration (evaluated only in D_IDLE with DMA pending):
  - DMA wins if CPU_req=0, or if starve counter == STARVE_MAX; otherwise CPU wins.
  - Starve counter increments (saturating) each cycle DMA is pending and loses.
  - It clears on DMA grant and when DMA_en=0.
  - STARVE_MAX=0 gives DMA absolute priority.
- CPU gets the slot whenever DMA is not granted, including during D_WAIT and D_STROBE.
- CPU_stall = CPU_req & ~cpu_grant (combinational).
- CPU read granted in cycle N produces CPU_qvalid=1 in cycle N+1, with CPU_q=RAM_q combinational in that cycle. CPU writes give no qvalid.
- DMA_en dropping in D_WAIT or D_STROBE: the access completes and the strobe is still issued.
- Address arithmetic is external; no wrap is performed here.

Optional Feature:
- Macro DMA_WRITE_EN.
- Defined: DMA_wren is honoured; RAM_wren=DMA_wren on a DMA grant, and DMA_q echoes DMA_data on writes.
- Undefined: DMA port is read-only. DMA_wren is ignored, RAM_wren is never asserted by a DMA grant, and DMA_q always carries read data.

Test Plan:
- CPU idle, DMA_en=1, RAM[F000]=1234, DMA_addr=F000 → RAM_addr=F000 in cycle 0; DMA_q=1234 with DMA_CLOCK=1 in cycle 2; DMA_CLOCK=0 in cycle 3; next grant in cycle 3.
- CPU_req held high (reads), DMA_en=1, STARVE_MAX=8 → DMA loses 8 cycles, is granted on the 9th with CPU_stall=1 that cycle only; CPU_qvalid resumes 2 cycles later.
- CPU read of 0x0010 (=BEEF) while DMA in D_WAIT → CPU granted, CPU_qvalid=1 with CPU_q=BEEF next cycle; DMA strobe timing unaffected.
- RST_N pulsed low during D_WAIT → DMA_CLOCK stays 0, DMA_q=0, FSM in D_IDLE, counter 0; on release with DMA_en=1, the first grant occurs in the first cycle.
- DMA_en=1, DMA_wren=1, DMA_data=00AA at 0x8000 → with DMA_WRITE_EN: RAM[8000]=00AA and DMA_q=00AA at the strobe; without: RAM_wren=0 and DMA_q=old RAM[8000].
- DMA_en deasserted in D_WAIT → the strobe is still issued once; no further grants while DMA_en=0.
